// File: rtl/dotmatrix_scan_driver_if.sv
// Bus between the dot-matrix frame source and the scan driver.
// master: frame source / display controller side; slave: the scan driver.
interface dotmatrix_scan_driver_if;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned LINE_W  = 4;

  logic                power;
  logic [FRAME_W-1:0]  frame;
  logic [LINE_W-1:0]   row_sel;
  logic [LINE_W-1:0]   col_data;
  logic                frame_start;
  logic                onehot_err;

  modport master (
    output power,
    output frame,
    input  row_sel,
    input  col_data,
    input  frame_start,
    input  onehot_err
  );

  modport slave (
    input  power,
    input  frame,
    output row_sel,
    output col_data,
    output frame_start,
    output onehot_err
  );
endinterface

// File: rtl/dotmatrix_scan_driver.sv
// Row-multiplexed 4x4 LED scan driver with per-row blanking and a frame
// shadow register that is only reloaded at frame boundaries.
// Optional macro DOTMATRIX_ONEHOT_CHECK_EN adds a latched flag that is set
// when the frame captured at a boundary does not have exactly one lit pixel.
module dotmatrix_scan_driver #(
  parameter int unsigned DIV            = 1000,
  parameter int unsigned BLANK          = 8,
  parameter bit          COL_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  dotmatrix_scan_driver_if.slave  bus
);

  localparam int unsigned CNT_W   = $clog2(DIV);
  localparam int unsigned ROW_W   = 2;
  localparam int unsigned LINE_W  = 4;
  localparam int unsigned FRAME_W = 16;

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(3);
  localparam logic [LINE_W-1:0] COL_OFF   = COL_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic [LINE_W-1:0]  row_sel_q, row_sel_d;
  logic [LINE_W-1:0]  col_q, col_d;
  logic               fs_q, fs_d;
  logic               boundary_c;

  // Next scan position, shadow reload and output decode of the new position
  always_comb begin
    cnt_d      = cnt_q;
    row_d      = row_q;
    shadow_d   = shadow_q;
    row_sel_d  = '0;
    col_d      = COL_OFF;
    fs_d       = 1'b0;
    boundary_c = 1'b0;

    if (!bus.power) begin
      // Park just before a boundary so restart begins with a fresh frame
      cnt_d = CNT_MAX;
      row_d = ROW_LAST;
    end else begin
      boundary_c = (cnt_q == CNT_MAX) && (row_q == ROW_LAST);
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (boundary_c) begin
        shadow_d = bus.frame;
        fs_d     = 1'b1;
      end
      if (cnt_d >= CNT_BLANK) begin
        row_sel_d = 4'b0001 << row_d;
        col_d     = shadow_d[{row_d, 2'b00} +: LINE_W] ^ COL_OFF;
      end
    end
  end

  // Scan state and registered outputs; reset has priority
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= CNT_MAX;
      row_q     <= ROW_LAST;
      shadow_q  <= '0;
      row_sel_q <= '0;
      col_q     <= COL_OFF;
      fs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      shadow_q  <= shadow_d;
      row_sel_q <= row_sel_d;
      col_q     <= col_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.row_sel     = row_sel_q;
  assign bus.col_data    = col_q;
  assign bus.frame_start = fs_q;

`ifdef DOTMATRIX_ONEHOT_CHECK_EN
  logic err_q;
  logic frame_bad_c;

  // Zero lit pixels, or more than one, means the cursor was lost or duplicated
  assign frame_bad_c = (bus.frame == '0) ||
                       ((bus.frame & (bus.frame - FRAME_W'(1))) != '0);

  // Validity flag captured with the frame and held until the next boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (boundary_c) begin
      err_q <= frame_bad_c;
    end
  end

  assign bus.onehot_err = err_q;
`else
  assign bus.onehot_err = 1'b0;
`endif

endmodule

// File: tb/tb_dotmatrix_scan_driver.sv
// Scoreboard bench for dotmatrix_scan_driver (DIV=8, BLANK=2).
// dut0: active-high columns with a changing frame sequence.
// dut1: active-low columns with a constant frame holding only y11.
module tb_dotmatrix_scan_driver;

  typedef struct {
    int         cyc;
    logic [3:0] rs;
    logic [3:0] cd;
    logic       fs;
    logic       err;
  } exp_t;

`ifdef DOTMATRIX_ONEHOT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  dotmatrix_scan_driver_if bus0 ();
  dotmatrix_scan_driver_if bus1 ();

  dotmatrix_scan_driver #(.DIV(8), .BLANK(2), .COL_ACTIVE_LOW(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  dotmatrix_scan_driver #(.DIV(8), .BLANK(2), .COL_ACTIVE_LOW(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  // Count active edges so expectations can name the edge they belong to
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic push(input int dut, input exp_t x);
    if (dut == 0) q0.push_back(x);
    else          q1.push_back(x);
  endtask

  // Expected outputs for n edges of a frame starting at a boundary edge
  task automatic push_frame(input int dut, input int start, input int n,
                            input logic [15:0] sh, input logic e,
                            input logic [3:0] off);
    exp_t x;
    int   c;
    int   r;
    for (int k = 0; k < n; k++) begin
      c     = k % 8;
      r     = k / 8;
      x.cyc = start + k;
      x.fs  = (k == 0);
      x.err = e & CHK;
      if (c < 2) begin
        x.rs = 4'b0000;
        x.cd = off;
      end else begin
        x.rs = 4'(1 << r);
        x.cd = 4'(sh >> (4 * r)) ^ off;
      end
      push(dut, x);
    end
  endtask

  // Expected outputs for n edges of reset or power-off
  task automatic push_off(input int dut, input int start, input int n,
                          input logic e, input logic [3:0] off);
    exp_t x;
    for (int k = 0; k < n; k++) begin
      x.cyc = start + k;
      x.rs  = 4'b0000;
      x.cd  = off;
      x.fs  = 1'b0;
      x.err = e & CHK;
      push(dut, x);
    end
  endtask

  task automatic check_one(input int dut, input exp_t x,
                           input logic [3:0] rs, input logic [3:0] cd,
                           input logic fs, input logic er);
    checks++;
    if (x.cyc != edge_n || rs !== x.rs || cd !== x.cd || fs !== x.fs || er !== x.err) begin
      errors++;
      $display("FAIL dut%0d edge %0d (expected for edge %0d): row_sel=%b col_data=%b frame_start=%b onehot_err=%b, want %b %b %b %b",
               dut, edge_n, x.cyc, rs, cd, fs, er, x.rs, x.cd, x.fs, x.err);
    end
  endtask

  // Monitor: compare every queued expectation due at this edge
  always @(negedge clk) begin
    exp_t x;
    while (q0.size() > 0 && q0[0].cyc <= edge_n) begin
      x = q0.pop_front();
      check_one(0, x, bus0.row_sel, bus0.col_data, bus0.frame_start, bus0.onehot_err);
    end
    while (q1.size() > 0 && q1[0].cyc <= edge_n) begin
      x = q1.pop_front();
      check_one(1, x, bus1.row_sel, bus1.col_data, bus1.frame_start, bus1.onehot_err);
    end
  end

  task automatic goto(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_power(input logic p);
    bus0.power = p;
    bus1.power = p;
  endtask

  initial begin
    reset      = 1'b1;
    set_power(1'b1);
    bus0.frame = 16'h0001;
    bus1.frame = 16'h0020;
    push_off(0, 1, 3, 1'b0, 4'h0);
    push_off(1, 1, 3, 1'b0, 4'hF);

    // Release reset: edge 4 is the first boundary
    goto(3);
    reset = 1'b0;
    push_frame(0, 4, 32, 16'h0001, 1'b0, 4'h0);
    push_frame(1, 4, 32, 16'h0020, 1'b0, 4'hF);

    // Mid-frame change only appears after the next boundary (edge 36)
    goto(13);
    bus0.frame = 16'h8000;
    push_frame(0, 36, 32, 16'h8000, 1'b0, 4'h0);
    push_frame(1, 36, 32, 16'h0020, 1'b0, 4'hF);

    goto(40);
    bus0.frame = 16'h0000;
    push_frame(0, 68, 32, 16'h0000, 1'b1, 4'h0);
    push_frame(1, 68, 32, 16'h0020, 1'b0, 4'hF);

    goto(80);
    bus0.frame = 16'h0010;
    push_frame(0, 100, 32, 16'h0010, 1'b0, 4'h0);
    push_frame(1, 100, 32, 16'h0020, 1'b0, 4'hF);

    goto(110);
    bus0.frame = 16'h0003;
    push_frame(0, 132, 14, 16'h0003, 1'b1, 4'h0);
    push_frame(1, 132, 14, 16'h0020, 1'b0, 4'hF);

    // Power drop while row 1 is lit; flag holds, outputs blank next edge
    goto(145);
    set_power(1'b0);
    bus0.frame = 16'h0180;
    push_off(0, 146, 6, 1'b1, 4'h0);
    push_off(1, 146, 6, 1'b0, 4'hF);

    // Power restore: first counting edge is a boundary and relatches
    goto(151);
    set_power(1'b1);
    push_frame(0, 152, 32, 16'h0180, 1'b1, 4'h0);
    push_frame(1, 152, 32, 16'h0020, 1'b0, 4'hF);
    push_frame(0, 184, 12, 16'h0180, 1'b1, 4'h0);
    push_frame(1, 184, 12, 16'h0020, 1'b0, 4'hF);

    // Reset mid row 1 clears outputs and the flag at once
    goto(195);
    reset = 1'b1;
    push_off(0, 196, 2, 1'b0, 4'h0);
    push_off(1, 196, 2, 1'b0, 4'hF);

    goto(197);
    reset = 1'b0;
    bus0.frame = 16'h0004;
    push_frame(0, 198, 32, 16'h0004, 1'b0, 4'h0);
    push_frame(1, 198, 32, 16'h0020, 1'b0, 4'hF);

    goto(232);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending dut0=%0d dut1=%0d, want 0 0", q0.size(), q1.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: edge_n=%0d, want bench to finish by edge 232", edge_n);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dotmatrix_scan_driver.md
Name: dotmatrix_scan_driver

Overview:
- Display-side end of the 4x4 dot-matrix LED interface.
- Takes the 16 per-LED lines produced by the dot-matrix position controller, presented as one flat frame word.
- Drives a physical row-multiplexed 4x4 LED array: one row at a time, with a blanking gap between rows to prevent ghosting.
- Latches the frame only at frame boundaries, so a cursor move never tears mid-scan.

Parameters:
- DIV, 1000: clock cycles per row slot; legal range DIV >= 2.
- BLANK, 8: blanked cycles at the start of each row slot; legal range 0 <= BLANK < DIV.
- COL_ACTIVE_LOW, 0: when 1, col_data is inverted, so the lit/inactive levels swap.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- power  in  1  display enable; when 0, the scan is held off.
- frame  in  16  pixel lines; frame[4*r+c] = LED y_rc (row r, column c; y00 = bit0, y33 = bit15).
- row_sel  out  4  one-hot active-high row drive; row_sel[r] selects row r.
- col_data  out  4  column drive for the selected row; col_data[c] = pixel (r,c).
- frame_start  out  1  one-cycle pulse marking a new frame latch.
- onehot_err  out  1  frame-validity flag; see Optional Feature.

Behaviour:
- State:
  - prescaler cnt, 0..DIV-1, width $clog2(DIV).
  - row index r, 0..3.
  - shadow frame register, 16 bits.
- All outputs are registered. After any edge, outputs decode the (cnt, r, shadow) values written on that same edge, so there is no extra cycle of lag.
- Reset (synchronous, highest priority):
  - cnt=DIV-1, r=3, shadow=0.
  - row_sel=0, col_data=inactive (0000, or 1111 if COL_ACTIVE_LOW), frame_start=0, onehot_err=0.
- Power low (reset low):
  - Same counter and output values as reset.
  - shadow and onehot_err hold their values.
- Counting (reset=0, power=1), each edge:
  - cnt increments; at DIV-1 it wraps to 0 and r increments (3 wraps to 0).
- Frame boundary = the edge where cnt wraps DIV-1->0 and r wraps 3->0. On that edge:
  - shadow <= frame.
  - frame_start <= 1.
  - On all other edges frame_start <= 0.
- The first counting edge after reset or power restore is therefore always a frame boundary.
- Row slot decode:
  - cnt < BLANK: row_sel=0, col_data=inactive.
  - cnt >= BLANK: row_sel=1<<r, col_data=shadow[4r+3:4r], inverted if COL_ACTIVE_LOW.
- Timing:
  - Frame period 4*DIV cycles.
  - Each row lit DIV-BLANK consecutive cycles.
  - Never more than one row_sel bit is high; at least BLANK cycles of all-off between rows.
- frame changes between boundaries have no effect on the outputs until the next boundary.
- Reset or power drop mid-row blanks the outputs on the very next edge; there is no partial-slot completion.
- Empty or multi-lit frames are displayed as given; the driver does not filter them.

Optional Feature:
- Macro: DOTMATRIX_ONEHOT_CHECK_EN.
- Defined:
  - On each frame boundary, onehot_err <= 1 when popcount(frame) != 1, else 0.
  - The value holds until the next boundary; reset clears it to 0.
  - This flags controller faults where the cursor is lost or duplicated.
- Undefined:
  - onehot_err is tied to constant 0.
  - No popcount logic is synthesized.

Test Plan (DIV=8, BLANK=2, COL_ACTIVE_LOW=0 unless noted):
1. Reset 3 cycles, release, frame=0x0001:
   - Edge E0: frame_start=1, row_sel=0.
   - E2..E7: row_sel=0001, col_data=0001.
   - Rows 1..3: col_data=0000 in their active windows.
   - Next frame_start at E32.
2. frame=0x0001 at boundary, then 0x8000 applied at E10:
   - Row 0 keeps col_data=0001 until E32.
   - From E32 on: row 3 window (E58..E63) shows row_sel=1000, col_data=1000.
3. power=0 at E13 (row 1 lit):
   - E14: row_sel=0, col_data=0000.
   - power=1 at E20: E21 frame_start=1 and shadow relatched; row 0 lit at E23.
4. reset pulsed at E40 mid-row-1:
   - Outputs off the next edge and shadow=0.
   - Release: first edge is a boundary with frame_start=1.
5. DOTMATRIX_ONEHOT_CHECK_EN defined, frames 0x0000, 0x0003, 0x0010 latched on successive boundaries:
   - onehot_err = 1, 1, 0 respectively.
   - With the macro undefined, onehot_err stays 0 throughout.
6. COL_ACTIVE_LOW=1, frame=0x0020 (y11):
   - Blank windows: col_data=1111.
   - Row 1 active window: row_sel=0010, col_data=1101.
   - Other rows' active windows: col_data=1111.
